// File: rtl/prbs_pkg.sv
// Shared PRBS7 definitions (x^7 + x^6 + 1) used by the generator and the checker.
package prbs_pkg;

    localparam int unsigned Prbs7Len  = 7;
    localparam int unsigned Prbs7TapA = 6;
    localparam int unsigned Prbs7TapB = 5;

    localparam logic [Prbs7Len-1:0] Prbs7Zero = '0;

    typedef enum logic [1:0] {
        StSeed,
        StVerify,
        StLocked
    } prbs_state_e;

    function automatic logic prbs7_pred(input logic [Prbs7Len-1:0] s);
        return s[Prbs7TapA] ^ s[Prbs7TapB];
    endfunction

endpackage

// File: rtl/prbs7_predictor.sv
// 7-bit PRBS7 predictor register: shifts in either the received bit or its own prediction.
module prbs7_predictor
    import prbs_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_en_i,
    input  logic sel_pred_i,
    input  logic clear_i,
    input  logic din_i,
    output logic pred_o,
    output logic din_zero_o
);

    logic [Prbs7Len-1:0] s_q, s_d;

    assign pred_o = prbs7_pred(s_q);

    // Register would be all-zero if din were shifted in this cycle.
    assign din_zero_o = ({s_q[Prbs7Len-2:0], din_i} == Prbs7Zero);

    always_comb begin
        s_d = s_q;
        if (clear_i) begin
            s_d = Prbs7Zero;
        end else if (load_en_i) begin
            s_d = {s_q[Prbs7Len-2:0], (sel_pred_i ? pred_o : din_i)};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q <= Prbs7Zero;
        end else begin
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS7 checker: seeds, verifies, then counts errors and detects loss of sync.
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned LOCK_COUNT  = 16,
    parameter int unsigned WINDOW      = 32,
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic                 din,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [7:0]           resync_count
);

    localparam int unsigned SeedW  = 3;
    localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WinW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned WerrW  = $clog2(LOSS_THRESH + 1);

    prbs_state_e          state_q, state_d;
    logic [SeedW-1:0]     seed_cnt_q, seed_cnt_d;
    logic [MatchW-1:0]    match_q, match_d;
    logic [WinW-1:0]      win_bit_q, win_bit_d;
    logic [WerrW-1:0]     win_err_q, win_err_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [7:0]           resync_q, resync_d;
    logic                 locked_q, locked_d;
    logic                 err_pulse_q, err_pulse_d;

    logic pred, din_zero, mismatch;
    logic pred_load, pred_sel, pred_clear;

    prbs7_predictor u_predictor (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_en_i  (pred_load),
        .sel_pred_i (pred_sel),
        .clear_i    (pred_clear),
        .din_i      (din),
        .pred_o     (pred),
        .din_zero_o (din_zero)
    );

    assign mismatch = (din != pred);

    always_comb begin
        state_d     = state_q;
        seed_cnt_d  = seed_cnt_q;
        match_d     = match_q;
        win_bit_d   = win_bit_q;
        win_err_d   = win_err_q;
        err_count_d = err_count_q;
        resync_d    = resync_q;
        err_pulse_d = 1'b0;
        pred_load   = 1'b0;
        pred_sel    = 1'b0;
        pred_clear  = 1'b0;

        if (valid) begin
            unique case (state_q)
                StSeed: begin
                    pred_load = 1'b1;
                    if (seed_cnt_q == SeedW'(Prbs7Len - 1)) begin
                        state_d    = StVerify;
                        seed_cnt_d = '0;
                        match_d    = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 1'b1;
                    end
                end
                StVerify: begin
                    pred_load = 1'b1;
                    if (din_zero) begin
                        // Stuck-at-0 input can never be a legal PRBS7 state.
                        state_d    = StSeed;
                        seed_cnt_d = '0;
                        match_d    = '0;
                    end else if (mismatch) begin
                        match_d = '0;
                    end else if (match_q == MatchW'(LOCK_COUNT - 1)) begin
                        state_d   = StLocked;
                        match_d   = '0;
                        win_bit_d = '0;
                        win_err_d = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                StLocked: begin
                    // Free-running predictor so a single bad bit does not corrupt later predictions.
                    pred_load = 1'b1;
                    pred_sel  = 1'b1;
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != {CNT_WIDTH{1'b1}}) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                    end
                    if (mismatch && (win_err_q == WerrW'(LOSS_THRESH - 1))) begin
                        state_d    = StSeed;
                        pred_clear = 1'b1;
                        seed_cnt_d = '0;
                        match_d    = '0;
                        win_bit_d  = '0;
                        win_err_d  = '0;
                        if (resync_q != 8'hFF) begin
                            resync_d = resync_q + 1'b1;
                        end
                    end else if (win_bit_q == WinW'(WINDOW - 1)) begin
                        win_bit_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_bit_d = win_bit_q + 1'b1;
                        if (mismatch) begin
                            win_err_d = win_err_q + 1'b1;
                        end
                    end
                end
                default: state_d = StSeed;
            endcase
        end

        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSeed;
            seed_cnt_q  <= '0;
            match_q     <= '0;
            win_bit_q   <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            resync_q    <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_cnt_q  <= seed_cnt_d;
            match_q     <= match_d;
            win_bit_q   <= win_bit_d;
            win_err_q   <= win_err_d;
            err_count_q <= err_count_d;
            resync_q    <= resync_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked       = locked_q;
    assign err_pulse    = err_pulse_q;
    assign err_count    = err_count_q;
    assign resync_count = resync_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed testbench for prbs7_checker: segment table plus hand-written reset/stuck-at sequences.
module tb_prbs7_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        din;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [7:0]  resync_count;

    always #5 clk = ~clk;

    prbs7_checker #(
        .CNT_WIDTH   (16),
        .LOCK_COUNT  (16),
        .WINDOW      (32),
        .LOSS_THRESH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid),
        .din          (din),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .resync_count (resync_count)
    );

    typedef struct {
        bit          rst_first;
        bit          gap;
        int          nbits;
        logic [31:0] flips;
        int          exp_locked;
        int          exp_err;
        int          exp_resync;
        int          exp_pulses;
    } seg_t;

    seg_t       segs[9];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         pulses = 0;
    logic [6:0] g      = 7'h5A;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference PRBS7 source: x^7 + x^6 + 1.
    task automatic next_bit(output logic b);
        b = g[6] ^ g[5];
        g = {g[5:0], b};
    endtask

    task automatic cycle(input logic v, input logic d);
        @(negedge clk);
        valid = v;
        din   = d;
        @(posedge clk);
        #1;
        if (err_pulse === 1'b1) pulses++;
    endtask

    task automatic send(input logic flip, input logic gap);
        logic b;
        next_bit(b);
        cycle(1'b1, b ^ flip);
        if (gap) cycle(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        din   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int seen_locked;
        rst   = 1'b1;
        valid = 1'b0;
        din   = 1'b0;

        // Segments run back to back; the window counter starts on the first bit after lock.
        segs[0] = '{1'b0, 1'b0, 977, 32'h0000_0000, 1, 0, 0, 0};
        segs[1] = '{1'b0, 1'b0, 20,  32'h0000_0020, 1, 1, 0, 1};
        segs[2] = '{1'b0, 1'b0, 20,  32'h0000_0055, 0, 5, 1, 4};
        segs[3] = '{1'b0, 1'b0, 9,   32'h0000_0000, 0, 5, 1, 0};
        segs[4] = '{1'b0, 1'b0, 1,   32'h0000_0000, 1, 5, 1, 0};
        segs[5] = '{1'b0, 1'b0, 32,  32'hE000_0000, 1, 8, 1, 3};
        segs[6] = '{1'b0, 1'b0, 8,   32'h0000_0001, 1, 9, 1, 1};
        segs[7] = '{1'b1, 1'b1, 22,  32'h0000_0000, 0, 0, 0, 0};
        segs[8] = '{1'b0, 1'b1, 1,   32'h0000_0000, 1, 0, 0, 0};

        do_reset();
        check("reset_locked", int'(locked), 0);
        check("reset_err_pulse", int'(err_pulse), 0);
        check("reset_err_count", int'(err_count), 0);
        check("reset_resync_count", int'(resync_count), 0);

        // Gapless lock timing: 7 seed bits + 16 matches.
        pulses = 0;
        for (int i = 0; i < 22; i++) send(1'b0, 1'b0);
        check("lock_not_before_bit23", int'(locked), 0);
        send(1'b0, 1'b0);
        check("lock_after_bit23", int'(locked), 1);
        check("lock_no_pulses", pulses, 0);

        for (int r = 0; r < 9; r++) begin
            if (segs[r].rst_first) do_reset();
            pulses = 0;
            for (int i = 0; i < segs[r].nbits; i++) begin
                send((i < 32) ? segs[r].flips[i] : 1'b0, segs[r].gap);
            end
            check($sformatf("seg%0d_locked", r), int'(locked), segs[r].exp_locked);
            check($sformatf("seg%0d_err_count", r), int'(err_count), segs[r].exp_err);
            check($sformatf("seg%0d_resync_count", r), int'(resync_count), segs[r].exp_resync);
            check($sformatf("seg%0d_pulses", r), pulses, segs[r].exp_pulses);
        end

        // Reset while locked with an error pulse in flight.
        send(1'b1, 1'b0);
        check("pre_rst_err_pulse", int'(err_pulse), 1);
        check("pre_rst_err_count", int'(err_count), 1);
        do_reset();
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_err_pulse", int'(err_pulse), 0);
        check("mid_rst_err_count", int'(err_count), 0);
        check("mid_rst_resync_count", int'(resync_count), 0);

        // Stuck-at-0 input must never lock.
        seen_locked = 0;
        pulses      = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 1'b0);
            if (locked === 1'b1) seen_locked = 1;
        end
        check("stuck0_never_locked", seen_locked, 0);
        check("stuck0_err_count", int'(err_count), 0);
        check("stuck0_pulses", pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
